// File: rtl/shift_arbiter_if.sv
// ============================================================================
// Module : shift_arbiter_if
// Brief  : Two-requester shift request bus plus single response channel.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface shift_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_data;
  logic [4:0]  a_amt;
  logic [1:0]  a_mode;

  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_data;
  logic [4:0]  b_amt;
  logic [1:0]  b_mode;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output a_valid, a_data, a_amt, a_mode,
    output b_valid, b_data, b_amt, b_mode,
    output rsp_ready,
    input  a_ready, b_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  a_valid, a_data, a_amt, a_mode,
    input  b_valid, b_data, b_amt, b_mode,
    input  rsp_ready,
    output a_ready, b_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/shift_arbiter.sv
// ============================================================================
// Module : shift_arbiter (with shifter_32bit)
// Brief  : Arbitrates two requesters onto one shared 32-bit shifter with a
//          single-entry result register. Define SHIFT_ARBITER_RR_EN for
//          strict round-robin; otherwise A has priority with starvation guard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module shifter_32bit (
  input  logic [31:0] data,
  input  logic [4:0]  amt,
  input  logic [1:0]  mode,
  output logic [31:0] result
);
  always_comb begin
    result = data;
    case (mode)
      2'b00:   result = data >> amt;
      2'b01:   result = data << amt;
      2'b10:   result = $signed(data) >>> amt;
      default: result = data;
    endcase
  end
endmodule

module shift_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  shift_arbiter_if.slave bus
);
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rsp_err_q, rsp_err_d;
  // last_q: 0 = A granted last, 1 = B granted last
  logic        last_q, last_d;

  logic        can_accept;
  logic        contention;
  logic        grant_b;
  logic        accept;
  logic [31:0] sh_data;
  logic [4:0]  sh_amt;
  logic [1:0]  sh_mode;
  logic [31:0] sh_result;

`ifdef SHIFT_ARBITER_RR_EN
  always_comb begin
    grant_b = bus.b_valid & ~bus.a_valid;
    if (contention) begin
      grant_b = ~last_q;
    end
  end
`else
  logic [3:0] streak_q, streak_d;

  always_comb begin
    grant_b = bus.b_valid & ~bus.a_valid;
    if (contention) begin
      grant_b = ~last_q && (32'(streak_q) >= STARVE_LIMIT);
    end
  end

  // Streak counts back-to-back grants to one id only while the other waits.
  always_comb begin
    streak_d = streak_q;
    if (accept) begin
      if (!contention) begin
        streak_d = 4'd0;
      end else if (grant_b == last_q) begin
        streak_d = (streak_q == 4'hF) ? 4'hF : streak_q + 4'd1;
      end else begin
        streak_d = 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= 4'd0;
    end else begin
      streak_q <= streak_d;
    end
  end
`endif

  assign can_accept = (state_q == EMPTY) || bus.rsp_ready;
  assign contention = bus.a_valid & bus.b_valid;
  assign accept     = can_accept & (bus.a_valid | bus.b_valid);

  assign sh_data = grant_b ? bus.b_data : bus.a_data;
  assign sh_amt  = grant_b ? bus.b_amt  : bus.a_amt;
  assign sh_mode = grant_b ? bus.b_mode : bus.a_mode;

  shifter_32bit u_shifter (
    .data   (sh_data),
    .amt    (sh_amt),
    .mode   (sh_mode),
    .result (sh_result)
  );

  // Readies are gated by rst directly since the state reads as EMPTY during reset.
  assign bus.a_ready = accept & ~grant_b & ~rst;
  assign bus.b_ready = accept &  grant_b & ~rst;

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_err_d  = rsp_err_q;
    last_d     = last_q;
    if (accept) begin
      state_d    = FULL;
      rsp_data_d = sh_result;
      rsp_id_d   = grant_b;
      rsp_err_d  = (sh_mode == 2'b11);
      last_d     = grant_b;
    end else if (bus.rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      rsp_data_q <= 32'd0;
      rsp_id_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_err_q  <= rsp_err_d;
      last_q     <= last_d;
    end
  end

  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// ============================================================================
// Module : tb_shift_arbiter
// Brief  : Directed bench for shift_arbiter with a queue-based reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_shift_arbiter;
  localparam int unsigned STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  shift_arbiter_if bus ();

  shift_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: result register contents plus full grant history.
  logic        m_valid = 1'b0;
  logic        m_id    = 1'b0;
  logic [31:0] m_data  = 32'd0;
  logic        m_err   = 1'b0;
  int          hist_id[$];
  bit          hist_cont[$];

  logic p_accept, p_grant_b, p_a_ready, p_b_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] f_shift(input logic [31:0] d, input int amt, input logic [1:0] mode);
    logic [31:0] r;
    r = d;
    if (mode == 2'b00) r = d >> amt;
    else if (mode == 2'b01) r = d << amt;
    else if (mode == 2'b10) r = 32'($signed(d) >>> amt);
    return r;
  endfunction

  task automatic predict();
    int last;
    int run;
    last = (hist_id.size() == 0) ? 1 : hist_id[hist_id.size()-1];
    run  = 0;
    for (int i = hist_id.size() - 1; i >= 0; i--) begin
      if (hist_id[i] == last && hist_cont[i]) run++;
      else break;
    end
    p_accept = (!m_valid || bus.rsp_ready) && (bus.a_valid || bus.b_valid);
    if (bus.a_valid && bus.b_valid) begin
`ifdef SHIFT_ARBITER_RR_EN
      p_grant_b = (last == 0);
`else
      p_grant_b = (last == 0) && (run >= int'(STARVE_LIMIT));
`endif
    end else begin
      p_grant_b = bus.b_valid;
    end
    p_a_ready = !rst && p_accept && !p_grant_b;
    p_b_ready = !rst && p_accept &&  p_grant_b;
  endtask

  always @(posedge rst) begin
    m_valid = 1'b0; m_id = 1'b0; m_data = 32'd0; m_err = 1'b0;
    hist_id.delete();
    hist_cont.delete();
  end

  always @(posedge clk) begin
    if (!rst) begin
      predict();
      if (p_accept) begin
        m_valid = 1'b1;
        m_id    = p_grant_b;
        m_data  = p_grant_b ? f_shift(bus.b_data, int'(bus.b_amt), bus.b_mode)
                            : f_shift(bus.a_data, int'(bus.a_amt), bus.a_mode);
        m_err   = p_grant_b ? (bus.b_mode == 2'b11) : (bus.a_mode == 2'b11);
        hist_id.push_back(p_grant_b ? 1 : 0);
        hist_cont.push_back(bus.a_valid && bus.b_valid);
      end else if (bus.rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    predict();
    check("a_ready",   32'(bus.a_ready),   32'(p_a_ready));
    check("b_ready",   32'(bus.b_ready),   32'(p_b_ready));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    check("rsp_id",    32'(bus.rsp_id),    32'(m_id));
    check("rsp_data",  bus.rsp_data,       m_data);
    check("rsp_err",   32'(bus.rsp_err),   32'(m_err));
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [31:0] d, input logic [4:0] amt, input logic [1:0] mode);
    bus.a_valid = v; bus.a_data = d; bus.a_amt = amt; bus.a_mode = mode;
  endtask

  task automatic set_b(input logic v, input logic [31:0] d, input logic [4:0] amt, input logic [1:0] mode);
    bus.b_valid = v; bus.b_data = d; bus.b_amt = amt; bus.b_mode = mode;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_seq[10];
    int gid;
    set_a(1'b0, 32'd0, 5'd0, 2'b00);
    set_b(1'b0, 32'd0, 5'd0, 2'b00);
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_data",  bus.rsp_data,       32'd0);
    next_cycle();
    rst = 1'b0;

    // Single arithmetic-right operation
    set_a(1'b1, 32'h8000_0001, 5'd4, 2'b10);
    @(negedge clk);
    check("single a_ready", 32'(bus.a_ready), 32'd1);
    next_cycle();
    set_a(1'b0, 32'd0, 5'd0, 2'b00);
    @(negedge clk);
    check("single rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("single rsp_id",    32'(bus.rsp_id),    32'd0);
    check("single rsp_data",  bus.rsp_data,       32'hF800_0000);
    check("single rsp_err",   32'(bus.rsp_err),   32'd0);
    next_cycle();

    // Reserved mode passes through; max left shift
    set_b(1'b1, 32'h1234_5678, 5'd7, 2'b11);
    next_cycle();
    set_b(1'b1, 32'h0000_0001, 5'd31, 2'b01);
    @(negedge clk);
    check("reserved rsp_data", bus.rsp_data,     32'h1234_5678);
    check("reserved rsp_err",  32'(bus.rsp_err), 32'd1);
    check("reserved rsp_id",   32'(bus.rsp_id),  32'd1);
    next_cycle();
    set_b(1'b0, 32'd0, 5'd0, 2'b00);
    @(negedge clk);
    check("sll31 rsp_data", bus.rsp_data,     32'h8000_0000);
    check("sll31 rsp_err",  32'(bus.rsp_err), 32'd0);
    next_cycle();

    // Back-pressure: result held while B waits
    bus.rsp_ready = 1'b0;
    set_a(1'b1, 32'h0000_00F0, 5'd4, 2'b00);
    next_cycle();
    set_a(1'b0, 32'd0, 5'd0, 2'b00);
    set_b(1'b1, 32'h0000_0001, 5'd4, 2'b01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp b_ready", 32'(bus.b_ready), 32'd0);
      check("bp rsp_data", bus.rsp_data,    32'h0000_000F);
      next_cycle();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp release b_ready", 32'(bus.b_ready), 32'd1);
    next_cycle();
    set_b(1'b0, 32'd0, 5'd0, 2'b00);
    @(negedge clk);
    check("bp b rsp_id",   32'(bus.rsp_id), 32'd1);
    check("bp b rsp_data", bus.rsp_data,    32'h0000_0010);
    next_cycle();

    // Continuous contention
`ifdef SHIFT_ARBITER_RR_EN
    exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
    set_a(1'b1, 32'hF000_0000, 5'd1, 2'b10);
    set_b(1'b1, 32'h0000_0003, 5'd2, 2'b01);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      gid = bus.a_ready ? 0 : (bus.b_ready ? 1 : 2);
      check($sformatf("contention grant %0d", i), 32'(gid), 32'(exp_seq[i]));
      next_cycle();
    end
    set_a(1'b0, 32'd0, 5'd0, 2'b00);
    set_b(1'b0, 32'd0, 5'd0, 2'b00);
    next_cycle();

    // Reset while a result is held
    bus.rsp_ready = 1'b0;
    set_a(1'b1, 32'h0000_0F00, 5'd8, 2'b00);
    next_cycle();
    set_a(1'b0, 32'd0, 5'd0, 2'b00);
    @(negedge clk);
    check("pre-reset rsp_valid", 32'(bus.rsp_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid-reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid-reset rsp_data",  bus.rsp_data,       32'd0);
    check("mid-reset rsp_id",    32'(bus.rsp_id),    32'd0);
    check("mid-reset rsp_err",   32'(bus.rsp_err),   32'd0);
    set_a(1'b1, 32'd5, 5'd0, 2'b00);
    #1;
    check("mid-reset a_ready", 32'(bus.a_ready), 32'd0);
    set_a(1'b0, 32'd0, 5'd0, 2'b00);
    @(negedge clk);
    #2;
    rst = 1'b0;
    next_cycle();
    bus.rsp_ready = 1'b1;
    set_a(1'b1, 32'h0000_0040, 5'd2, 2'b00);
    set_b(1'b1, 32'h0000_0040, 5'd3, 2'b00);
    @(negedge clk);
    check("post-reset tie a_ready", 32'(bus.a_ready), 32'd1);
    check("post-reset tie b_ready", 32'(bus.b_ready), 32'd0);
    next_cycle();
    set_a(1'b0, 32'd0, 5'd0, 2'b00);
    set_b(1'b0, 32'd0, 5'd0, 2'b00);
    @(negedge clk);
    check("post-reset rsp_data", bus.rsp_data, 32'h0000_0010);
    next_cycle();
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, max consecutive grants to one requester while the other is pending (range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports a_valid / b_valid  input  1  each  requester A/B operation pending.
REQ-005 SHALL have ports a_ready / b_ready  output  1  each  requester A/B operation accepted this cycle.
REQ-006 SHALL have ports a_data / b_data  input  32, a_amt / b_amt  input  5, a_mode / b_mode  input  2  operand, shift amount, mode per requester.
REQ-007 SHALL have port rsp_valid  output  1  result register holds a valid result.
REQ-008 SHALL have port rsp_ready  input  1  consumer accepts the result.
REQ-009 SHALL have port rsp_id  output  1  result owner (0=A, 1=B).
REQ-010 SHALL have port rsp_data  output  32  shifted result.
REQ-011 SHALL have port rsp_err  output  1  result came from reserved mode 2'b11.

Function
REQ-012 SHALL instantiate one shifter_32bit, the single shared shift resource; modes 00 SRL, 01 SLL, 10 SRA, 11 reserved (data passes unshifted).
REQ-013 SHALL implement states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-014 SHALL define can_accept = EMPTY, or FULL with rsp_ready=1 (same-cycle drain and refill).
REQ-015 SHALL assert at most one of a_ready/b_ready per cycle, only when can_accept and the granted requester's valid is 1; ready is combinational from valid and state.
REQ-016 SHALL register shifter output, grant id, and (mode==2'b11) into rsp_data/rsp_id/rsp_err on the accept edge; latency exactly 1 cycle.
REQ-017 Transitions: EMPTY->FULL on accept; FULL->EMPTY on rsp_ready with no accept; FULL->FULL on rsp_ready with accept (new result), or on rsp_ready=0 (hold).
REQ-018 SHALL hold rsp_data, rsp_id, rsp_err stable while FULL and rsp_ready=0.
REQ-019 SHALL grant the sole valid requester when only one is valid.
REQ-020 When both are valid, SHALL grant per arbitration policy (REQ-026/027).
REQ-021 SHALL keep a 4-bit streak counter of consecutive grants to the same id while the other requester is valid; reset to 1 on grant switch, to 0 when the other is not valid at grant.
REQ-022 Requesters SHALL hold valid and operands stable until ready; the block does not check this.

Reset
REQ-023 On rst=1, asynchronously: state EMPTY, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, streak=0, last-grant=B (so A wins first tie).
REQ-024 a_ready/b_ready SHALL be 0 while rst=1.
REQ-025 Reset mid-operation SHALL discard any held result; no response is issued for it.

Configuration
REQ-026 With macro SHIFT_ARBITER_RR_EN defined: on contention, grant the requester not granted last (strict round-robin); streak counter and STARVE_LIMIT unused.
REQ-027 Without SHIFT_ARBITER_RR_EN: on contention, A has fixed priority, except B is granted when streak for A reaches STARVE_LIMIT; streak then restarts.

Verification
REQ-028 Single op: a_valid=1, a_data=32'h8000_0001, a_amt=4, a_mode=10 -> a_ready=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=32'hF800_0000, rsp_err=0.
REQ-029 Back-pressure: rsp_ready=0 with result held, b_valid=1 -> b_ready=0, rsp_data unchanged for 5 cycles; rsp_ready=1 -> b_ready=1 same cycle, B result next cycle.
REQ-030 Contention, both valid continuously, rsp_ready=1: RR_EN defined -> ids A,B,A,B...; undefined, STARVE_LIMIT=4 -> A,A,A,A,B,A,A,A,A,B.
REQ-031 Reserved/left: b_mode=11, b_data=32'h1234_5678, b_amt=7 -> rsp_data=32'h1234_5678, rsp_err=1; b_mode=01, b_amt=31, b_data=1 -> rsp_data=32'h8000_0000.
REQ-032 Reset mid-operation: rst pulsed asynchronously while FULL -> rsp_valid=0 immediately, outputs zero; first subsequent tie grants A.
